regfile_wr_ctrl: RTL and testbench
==================================

Name: regfile_wr_ctrl

Overview:
- Write-port controller for the 32x32 register file (single write port A3/WD3/WE3).
- After reset, sequences a clear of every register to zero.
- Then shares the write port between two writeback requesters, the ALU result (req0) and the load/memory result (req1), using round-robin arbitration with valid/ready handshakes.
- Drives the register-file write port directly from registered outputs.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NREGS, 32, number of registers cleared at init (2**ADDR_W).
- CLEAR_ON_RESET, 1, 1 = run INIT clear sequence after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; active-low and synchronous (low at a posedge resets the block).
- req0_valid  in  1  ALU writeback request.
- req0_addr  in  ADDR_W  ALU destination register.
- req0_data  in  DATA_W  ALU result.
- req0_ready  out  1  req0 accepted this cycle.
- req1_valid  in  1  load writeback request.
- req1_addr  in  ADDR_W  load destination register.
- req1_data  in  DATA_W  load data.
- req1_ready  out  1  req1 accepted this cycle.
- wr_en  out  1  to regfile WE3.
- wr_addr  out  ADDR_W  to regfile A3.
- wr_data  out  DATA_W  to regfile WD3.
- init_busy  out  1  high while the clear sequence runs.
- last_grant  out  1  index of the most recently granted requester.

Behaviour:
- States: INIT and RUN. Counter clr_cnt is ADDR_W bits.
- Reset (rst=0 at posedge):
  - State = INIT if CLEAR_ON_RESET=1, else RUN.
  - clr_cnt=0, wr_en=0, wr_addr=0, wr_data=0, last_grant=1.
  - init_busy=1 if CLEAR_ON_RESET=1, else 0.
  - Reset overrides any in-flight clear or write: wr_en goes 0 at that edge.
- INIT:
  - Each cycle registers wr_en=1, wr_addr=clr_cnt, wr_data=0, then clr_cnt++.
  - When clr_cnt==NREGS-1 is issued, the next state is RUN.
  - Result: wr_en is high for exactly NREGS consecutive cycles covering addresses 0..NREGS-1, x0 included.
  - init_busy drops on the same edge the FSM enters RUN.
  - req0_ready=req1_ready=0 throughout INIT; requests are held off, not dropped.
- RUN arbitration (combinational readies):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester != last_grant (round-robin). Right after reset last_grant=1, so req0 wins the first tie.
  - At most one ready is high per cycle. A ready never asserts without its valid.
  - A handshake is valid&&ready. Losing requesters must hold valid, addr and data stable until accepted.
- RUN write issue (latency 1):
  - On an accepted handshake, the next edge registers wr_addr/wr_data from the winner and sets last_grant=winner.
  - wr_en=1 unless the winner's addr==0. An x0 write is accepted (ready=1) but wr_en=0; wr_addr/wr_data still update.
  - With no handshake, wr_en=0 next cycle, and wr_addr/wr_data/last_grant hold.
- Same destination from both requesters: no merging. The writes are issued on successive cycles in grant order, so the later one wins in the register file.
- Sustained throughput: one write per cycle. With both requesters continuously valid, grants strictly alternate 0,1,0,1.
- clr_cnt wrap: it never wraps in INIT because the exit is taken at NREGS-1. In RUN, clr_cnt is don't-care and held.

Test Plan:
- Reset clear: hold rst=0 for 2 cycles, then release with no requests. Required: wr_en=1 for exactly 32 cycles, wr_addr 0..31 in order, wr_data=0, and init_busy falls on the cycle after addr 31 is issued.
- Requests during INIT: assert req0_valid (addr 5, data 0xDEADBEEF) from reset release. Required: req0_ready=0 for all 32 clear cycles, then 1 in the first RUN cycle. Next cycle: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF.
- Tie round-robin: both requests valid continuously in RUN (req0 addr 1 data 0x11, req1 addr 2 data 0x22). Required: grants 0,1,0,1 and wr_addr sequence 1,2,1,2, one write per cycle.
- x0 suppression: req1_valid with addr 0, data 0xFFFFFFFF. Required: req1_ready=1, wr_en=0 the next cycle, last_grant=1.
- Same-address conflict: both requests target addr 7 (req0 data 0xA, req1 data 0xB) with last_grant=0. Required: req1 is written first (0xB) and req0 next cycle (0xA), so a regfile read of x7 returns 0xA.
- Mid-operation reset: assert rst=0 during clear address 12. Required: wr_en=0 at that edge, and after release the clear restarts from address 0 for a full 32 cycles.

Source files
------------

// File: rtl/regfile_wr_ctrl.sv
// Write-port controller for the register file: clears every register after reset,
// then arbitrates the single write port between ALU (req0) and load (req1) writebacks.
module regfile_wr_ctrl #(
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned NREGS          = 32,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              init_busy,
    output logic              last_grant
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NREGS - 1);
    localparam state_t            RST_STATE  = (CLEAR_ON_RESET != 0) ? INIT : RUN;
    localparam logic              RST_BUSY   = (CLEAR_ON_RESET != 0);

    state_t            state, state_n;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_n;
    logic              wr_en_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [DATA_W-1:0] wr_data_n;
    logic              init_busy_n;
    logic              last_grant_n;
    logic              grant0, grant1;

    // Round-robin grant: on a tie the requester that did not win last time goes.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == RUN) begin
            if (req0_valid && (!req1_valid || last_grant)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        state_n      = state;
        clr_cnt_n    = clr_cnt;
        wr_en_n      = 1'b0;
        wr_addr_n    = wr_addr;
        wr_data_n    = wr_data;
        init_busy_n  = init_busy;
        last_grant_n = last_grant;
        case (state)
            INIT: begin
                wr_en_n   = 1'b1;
                wr_addr_n = clr_cnt;
                wr_data_n = '0;
                if (clr_cnt == LAST_ADDR) begin
                    state_n     = RUN;
                    init_busy_n = 1'b0;
                end else begin
                    clr_cnt_n = clr_cnt + ADDR_W'(1);
                end
            end
            RUN: begin
                // x0 is hardwired zero: accept the write but keep WE3 low.
                if (grant0) begin
                    wr_en_n      = (req0_addr != '0);
                    wr_addr_n    = req0_addr;
                    wr_data_n    = req0_data;
                    last_grant_n = 1'b0;
                end else if (grant1) begin
                    wr_en_n      = (req1_addr != '0);
                    wr_addr_n    = req1_addr;
                    wr_data_n    = req1_data;
                    last_grant_n = 1'b1;
                end
            end
            default: state_n = RST_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RST_STATE;
            clr_cnt    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            init_busy  <= RST_BUSY;
            last_grant <= 1'b1;
        end else begin
            state      <= state_n;
            clr_cnt    <= clr_cnt_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            init_busy  <= init_busy_n;
            last_grant <= last_grant_n;
        end
    end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Directed bench for regfile_wr_ctrl: reset clear, arbitration vectors,
// x0 suppression, same-address ordering and mid-clear reset with a held request.
module tb_regfile_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        init_busy, last_grant;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rf [32];

    regfile_wr_ctrl #(
        .ADDR_W(5), .DATA_W(32), .NREGS(32), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_busy(init_busy), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    // Register file model fed by the write port.
    always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        lg;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //              v0   a0     d0            v1   a1     d1            r0   r1   en   addr   data          lg
        vecs[0]  = '{1'b1, 5'd3, 32'h33,       1'b0, 5'd0, 32'h0,        1'b1,1'b0,1'b1,5'd3, 32'h33,       1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0,1'b0,1'b0,5'd3, 32'h33,       1'b0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h44,       1'b0,1'b1,1'b1,5'd4, 32'h44,       1'b1};
        vecs[3]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,       1'b1,1'b0,1'b1,5'd1, 32'h11,       1'b0};
        vecs[4]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,       1'b0,1'b1,1'b1,5'd2, 32'h22,       1'b1};
        vecs[5]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,       1'b1,1'b0,1'b1,5'd1, 32'h11,       1'b0};
        vecs[6]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,       1'b0,1'b1,1'b1,5'd2, 32'h22,       1'b1};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 1'b0,1'b1,1'b0,5'd0, 32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 32'h0,        1'b1,1'b0,1'b1,5'd9, 32'h99,       1'b0};
        vecs[9]  = '{1'b1, 5'd7, 32'hA,        1'b1, 5'd7, 32'hB,        1'b0,1'b1,1'b1,5'd7, 32'hB,        1'b1};
        vecs[10] = '{1'b1, 5'd7, 32'hA,        1'b0, 5'd0, 32'h0,        1'b1,1'b0,1'b1,5'd7, 32'hA,        1'b0};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0,1'b0,1'b0,5'd7, 32'hA,        1'b0};

        rst = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

        // Reset state after two reset cycles.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_init_busy", init_busy, 1);
        chk("rst_last_grant", last_grant, 1);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        rst = 1'b1;

        // Full clear sequence with no requests.
        for (int i = 0; i < 32; i++) begin
            tick();
            chk($sformatf("clr_en[%0d]", i), wr_en, 1);
            chk($sformatf("clr_addr[%0d]", i), wr_addr, 32'(i));
            chk($sformatf("clr_data[%0d]", i), wr_data, 0);
            chk($sformatf("clr_busy[%0d]", i), init_busy, (i < 31) ? 32'd1 : 32'd0);
        end
        tick();
        chk("clr_done_en", wr_en, 0);
        chk("clr_done_busy", init_busy, 0);

        // Arbitration vectors in RUN.
        for (int k = 0; k < 12; k++) begin
            req0_valid = vecs[k].v0; req0_addr = vecs[k].a0; req0_data = vecs[k].d0;
            req1_valid = vecs[k].v1; req1_addr = vecs[k].a1; req1_data = vecs[k].d1;
            #1;
            chk($sformatf("v%0d_ready0", k), req0_ready, vecs[k].r0);
            chk($sformatf("v%0d_ready1", k), req1_ready, vecs[k].r1);
            tick();
            chk($sformatf("v%0d_wr_en", k), wr_en, vecs[k].en);
            chk($sformatf("v%0d_wr_addr", k), wr_addr, vecs[k].addr);
            chk($sformatf("v%0d_wr_data", k), wr_data, vecs[k].data);
            chk($sformatf("v%0d_last_grant", k), last_grant, vecs[k].lg);
        end
        tick();
        chk("rf_x7_last_writer", rf[7], 32'hA);
        chk("rf_x0_zero", rf[0], 32'h0);
        chk("rf_x2", rf[2], 32'h22);

        // Mid-clear reset, with req0 held valid throughout.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        for (int i = 0; i <= 12; i++) begin
            tick();
            chk($sformatf("pre_addr[%0d]", i), wr_addr, 32'(i));
            chk($sformatf("pre_ready0[%0d]", i), req0_ready, 0);
        end
        rst = 1'b0;
        tick();
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_busy", init_busy, 1);
        chk("mid_rst_last_grant", last_grant, 1);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk($sformatf("re_en[%0d]", i), wr_en, 1);
            chk($sformatf("re_addr[%0d]", i), wr_addr, 32'(i));
            chk($sformatf("re_ready0[%0d]", i), req0_ready, (i == 31) ? 32'd1 : 32'd0);
        end
        tick();
        req0_valid = 1'b0;
        chk("held_req_en", wr_en, 1);
        chk("held_req_addr", wr_addr, 5);
        chk("held_req_data", wr_data, 32'hDEADBEEF);
        chk("held_req_lg", last_grant, 0);
        tick();
        chk("held_req_idle_en", wr_en, 0);
        chk("rf_x5", rf[5], 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
